// File: rtl/var_bw_mul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : var_bw_mul_pipe_if
//  Purpose  : Operand/product handshake bundle for var_bw_mul_pipe.
//             Upstream side:   in_valid, in_ready, mode, a, b
//             Downstream side: out_valid, out_ready, p, out_mode, out_err
//             master = environment (drives operands, accepts products)
//             slave  = multiplier pipeline
//  Revision : 1.0 - initial release
// ============================================================================
interface var_bw_mul_pipe_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic [1:0]     out_mode;
    logic           out_err;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, p, out_mode, out_err
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, p, out_mode, out_err
    );
endinterface
`default_nettype wire

// File: rtl/var_bw_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : var_bw_mul_pipe
//  Purpose  : Pipelined variable bit-width unsigned multiplier. Each operand
//             pair carries its own mode: one WxW product, two (W/2)x(W/2)
//             products or four (W/4)x(W/4) products; mode 3 is flagged as an
//             error and yields zero. Latency is STAGES cycles, throughput one
//             transaction per cycle, in-order delivery.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - var_bw_mul_pipe_if.slave (valid/ready in, valid/ready out)
//  Params   : W      - operand width, multiple of 4, >= 8
//             STAGES - register stages (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module var_bw_mul_pipe #(
    parameter int W      = 16,
    parameter int STAGES = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    var_bw_mul_pipe_if.slave   bus
);
    localparam int C_Q  = W / 4;   // quarter-lane width
    localparam int C_PW = 2 * C_Q; // quarter x quarter product width
    localparam int C_OW = 2 * W;   // full product width

    // Every mode is built from the same 16 quarter-by-quarter partial products.
    // A term (i,j) contributes only if quarters i and j sit in the same lane;
    // terms crossing a lane boundary are masked, so no carry can cross lanes.
    function automatic logic f_use(input logic [1:0] m, input int i, input int j);
        logic r;
        case (m)
            2'd0:    r = 1'b1;
            2'd1:    r = ((i / 2) == (j / 2));
            2'd2:    r = (i == j);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Term (i,j) has weight 2^(Q*(i+j)); within a lane this is the ordinary
    // schoolbook sum, and lane k lands at bit 2L*k automatically.
    function automatic logic [C_OW-1:0] f_sum(input logic [C_PW-1:0] pp [4][4]);
        logic [C_OW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = acc + (C_OW'(pp[i][j]) << (C_Q * (i + j)));
            end
        end
        return acc;
    endfunction

    logic                w_advance;
    logic [C_Q-1:0]      w_aq [4];
    logic [C_Q-1:0]      w_bq [4];
    logic [C_PW-1:0]     w_pp [4][4];
    logic [C_OW-1:0]     w_p_out;

    logic [STAGES-1:0]   r_vld;
    logic [STAGES-1:0]   r_err;
    logic [1:0]          r_mode [STAGES];

    // Whole pipe moves together; a stall freezes every stage, bubbles included.
    assign w_advance     = ~r_vld[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.out_mode  = r_mode[STAGES-1];
    assign bus.out_err   = r_err[STAGES-1];
    assign bus.p         = w_p_out;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_aq[i] = bus.a[C_Q*i +: C_Q];
            w_bq[i] = bus.b[C_Q*i +: C_Q];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_pp[i][j] = '0;
                if (f_use(bus.mode, i, j)) begin
                    w_pp[i][j] = C_PW'(w_aq[i]) * C_PW'(w_bq[j]);
                end
            end
        end
    end

    // Valid / side-band shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_mode[k] <= 2'd0;
            end
        end else if (w_advance) begin
            r_vld[0]  <= bus.in_valid;
            r_err[0]  <= (bus.mode == 2'd3);
            r_mode[0] <= bus.mode;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_err[k]  <= r_err[k-1];
                r_mode[k] <= r_mode[k-1];
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            logic [C_OW-1:0] r_p;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_p <= '0;
                end else if (w_advance) begin
                    r_p <= f_sum(w_pp);
                end
            end

            assign w_p_out = r_p;
        end else begin : g_multi
            // Stage 0 holds the masked partial products; the reduction sits
            // between stage 0 and stage 1, later stages only delay the result.
            logic [C_PW-1:0] r_pp [4][4];
            logic [C_OW-1:0] r_p  [1:STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            r_pp[i][j] <= '0;
                        end
                    end
                    for (int k = 1; k < STAGES; k++) begin
                        r_p[k] <= '0;
                    end
                end else if (w_advance) begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            r_pp[i][j] <= w_pp[i][j];
                        end
                    end
                    r_p[1] <= f_sum(r_pp);
                    for (int k = 2; k < STAGES; k++) begin
                        r_p[k] <= r_p[k-1];
                    end
                end
            end

            assign w_p_out = r_p[STAGES-1];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_var_bw_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_var_bw_mul_pipe
//  Purpose  : Self-checking bench for var_bw_mul_pipe (W=16, STAGES=3).
//             Directed vectors with literal expectations, plus a lane-wise
//             arithmetic model feeding an in-order scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_var_bw_mul_pipe;
    localparam int W      = 16;
    localparam int STAGES = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    var_bw_mul_pipe_if #(.W(W)) bus ();

    var_bw_mul_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] p;
        logic [1:0]  mode;
        logic        err;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t e_new;

    logic [31:0] prev_p;
    logic [1:0]  prev_mode;
    logic        prev_err;
    bit          prev_hold    = 1'b0;
    bit          count_en     = 1'b0;
    int          in_ready_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Lane-wise reference: split into N lanes, multiply, pack at 2L*i.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] a,
                                          input logic [15:0] b);
        longint unsigned r, n, lw, mask, ai, bi;
        r = 0;
        if (m == 2'd3) return 32'd0;
        n    = 64'd1 << m;
        lw   = 64'd16 / n;
        mask = (64'd1 << lw) - 1;
        for (int i = 0; i < int'(n); i++) begin
            ai = (longint'(a) >> (lw * i)) & mask;
            bi = (longint'(b) >> (lw * i)) & mask;
            r  = r | ((ai * bi) << (2 * lw * i));
        end
        return r[31:0];
    endfunction

    // Scoreboard / protocol monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_hold = 1'b0;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 1);
        end else begin
            chk("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready));
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_p", bus.p, prev_p);
                chk("hold_mode", bus.out_mode, prev_mode);
                chk("hold_err", bus.out_err, prev_err);
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got p=%0h, expected no output", bus.p);
                end else begin
                    chk("sb_p", bus.p, q[0].p);
                    chk("sb_mode", bus.out_mode, q[0].mode);
                    chk("sb_err", bus.out_err, q[0].err);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e_new.p    = model(bus.mode, bus.a, bus.b);
                e_new.mode = bus.mode;
                e_new.err  = (bus.mode == 2'd3);
                q.push_back(e_new);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_p    = bus.p;
            prev_mode = bus.out_mode;
            prev_err  = bus.out_err;
            if (count_en && !bus.in_ready) in_ready_low++;
        end
    end

    // One transaction into an empty pipe with out_ready=1; checks latency and
    // literal result. Called at posedge+1.
    task automatic single(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] ep, input logic [1:0] em, input logic ee,
                          input string tag);
        int k;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) break;
        end
        chk({tag, "_latency"}, k, 3);
        chk({tag, "_p"}, bus.p, ep);
        chk({tag, "_mode"}, bus.out_mode, em);
        chk({tag, "_err"}, bus.out_err, ee);
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and hold it until accepted. Called at posedge+1.
    task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected accept");
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((q.size() != 0 || bus.out_valid) && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    logic [1:0]  s_mode [8];
    logic [15:0] s_a    [8];
    logic [15:0] s_b    [8];

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("reset_p", bus.p, 0);
        chk("reset_out_mode", bus.out_mode, 0);
        chk("reset_out_err", bus.out_err, 0);
        // Inputs during reset must be dropped.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        // 1-3, 5: directed literals
        single(2'd0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 2'd0, 1'b0, "m0_ffff");
        single(2'd1, 16'h0302, 16'h0504, 32'h000F0008, 2'd1, 1'b0, "m1_small");
        single(2'd1, 16'hFFFF, 16'hFFFF, 32'hFE01FE01, 2'd1, 1'b0, "m1_ffff");
        single(2'd2, 16'h4321, 16'h5678, 32'h14120E08, 2'd2, 1'b0, "m2_small");
        single(2'd2, 16'hFFFF, 16'hFFFF, 32'hE1E1E1E1, 2'd2, 1'b0, "m2_ffff");
        single(2'd3, 16'h1234, 16'h5678, 32'h00000000, 2'd3, 1'b1, "m3_illegal");

        // 4: back-to-back stream with a 4-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            s_mode[i] = 2'(i % 3);
            s_a[i]    = 16'(16'h1357 * (i + 1) + 16'h00F1);
            s_b[i]    = 16'(16'h9ABD ^ (16'h0F0F << i));
        end
        in_ready_low = 0;
        count_en     = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(s_mode[i], s_a[i], s_b[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #2 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2 bus.out_ready = 1'b1;
            end
        join
        count_en = 1'b0;
        chk("stall_in_ready_low_cycles", in_ready_low, 4);
        drain("stream");

        // 5: illegal mode delivered in order between neighbours
        send(2'd1, 16'h0302, 16'h0504);
        send(2'd3, 16'h1234, 16'h5678);
        send(2'd2, 16'h4321, 16'h5678);
        drain("order");

        // 6: reset with two transactions in flight
        bus.out_ready = 1'b0;
        send(2'd0, 16'hABCD, 16'h1234);
        send(2'd1, 16'h7F80, 16'h0102);
        @(posedge clk);
        #3;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        single(2'd0, 16'h00C8, 16'h0003, 32'h00000258, 2'd0, 1'b0, "post_rst");
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
